// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared types and constants for the load/store unit.
//            - mem_size_t  : access size encoding on req_size
//            - lsu_state_t : LSU control FSM state encoding
//            - lane_t      : 4 x 8-bit memory lanes, lane k = byte at addr+k
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Access size as presented on req_size. Encoding 3 is not a member and is
    // flagged as illegal by the alignment checker.
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } mem_size_t;

    localparam logic [1:0] LSU_SIZE_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RESP    = 2'd3
    } lsu_state_t;

    // Packed so that lane_t[0] occupies bits [7:0]: little-endian word view.
    typedef logic [3:0][7:0] lane_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/riscv_lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : riscv_lsu_lane_align
// Purpose  : Purely combinational lane handling for the LSU.
//            - Misalignment / illegal-size check on an incoming request.
//            - Load extraction and sign/zero extension from the read lanes.
//            - Sub-word store merge of new byte(s) into the read lanes.
// Ports    : chk_offset_i/chk_size_i -> misaligned_o   (request check)
//            offset_i/size_i/unsigned_i/rlanes_i -> load_data_o
//            offset_i/size_i/wdata_i/rlanes_i    -> merged_o
// Revision : 1.0 - initial release
// ============================================================================
module riscv_lsu_lane_align
    import riscv_pkg::*;
(
    input  logic [1:0]  chk_offset_i,
    input  logic [1:0]  chk_size_i,
    output logic        misaligned_o,

    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [15:0] wdata_i,
    input  lane_t       rlanes_i,
    output logic [31:0] load_data_o,
    output lane_t       merged_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sext;

    always_comb begin
        misaligned_o = (chk_size_i == LSU_SIZE_ILLEGAL)
                     | ((chk_size_i == SIZE_H) & chk_offset_i[0])
                     | ((chk_size_i == SIZE_W) & (chk_offset_i != 2'b00));
    end

    always_comb begin
        w_byte = rlanes_i[offset_i];
        // Halfwords are 2-byte aligned, so offset_i[1] selects the lane pair.
        w_half = {rlanes_i[{offset_i[1], 1'b1}], rlanes_i[{offset_i[1], 1'b0}]};
        w_sext = ~unsigned_i;

        load_data_o = rlanes_i;
        case (size_i)
            SIZE_B:  load_data_o = {{24{w_sext & w_byte[7]}}, w_byte};
            SIZE_H:  load_data_o = {{16{w_sext & w_half[15]}}, w_half};
            default: load_data_o = rlanes_i;
        endcase
    end

    // Only sub-word stores go through the merge; word stores bypass it.
    always_comb begin
        merged_o = rlanes_i;
        case (size_i)
            SIZE_B: merged_o[offset_i] = wdata_i[7:0];
            SIZE_H: begin
                merged_o[{offset_i[1], 1'b0}] = wdata_i[7:0];
                merged_o[{offset_i[1], 1'b1}] = wdata_i[15:8];
            end
            default: merged_o = rlanes_i;
        endcase
    end

endmodule : riscv_lsu_lane_align
`default_nettype wire

// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : riscv_lsu
// Purpose  : Load/store unit between the core request path and a byte-lane
//            data memory with a whole-word write enable. One request at a
//            time; sub-word stores are done as read-modify-write.
// Ports    : clk_i, rst_b_i (synchronous, active-high)
//            req_*_i / req_ready_o      : request handshake and fields
//            resp_valid_o, resp_rdata_o, resp_misaligned_o : completion
//            mem_addr_o, mem_data_in_o, mem_data_out_i, mem_write_en_o
// Revision : 1.0 - initial release
// ============================================================================
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_b_i,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,

    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_misaligned_o,

    output logic [31:0] mem_addr_o,
    output lane_t       mem_data_in_o,
    input  lane_t       mem_data_out_i,
    output logic        mem_write_en_o
);

    localparam int                 c_CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [c_CNT_W-1:0] c_LAT   = c_CNT_W'(MEM_LATENCY);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    lsu_state_t         state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;

    // Registered request fields. Only the offset and the low halfword of the
    // store data are kept: word stores consume req_wdata_i at accept time.
    logic [1:0]         offset_q;
    logic [1:0]         size_q;
    logic               unsigned_q;
    logic               we_q;
    logic [15:0]        wdata_q;

    logic [31:0]        mem_addr_q;
    lane_t              mem_data_in_q;
    logic               mem_write_en_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_misaligned_q;

    logic               w_accept;
    logic               w_misaligned;
    logic               w_sample;
    logic               w_word_store;
    logic [31:0]        w_load_data;
    lane_t              w_merged;

    riscv_lsu_lane_align u_lane_align (
        .chk_offset_i (req_addr_i[1:0]),
        .chk_size_i   (req_size_i),
        .misaligned_o (w_misaligned),
        .offset_i     (offset_q),
        .size_i       (size_q),
        .unsigned_i   (unsigned_q),
        .wdata_i      (wdata_q),
        .rlanes_i     (mem_data_out_i),
        .load_data_o  (w_load_data),
        .merged_o     (w_merged)
    );

    assign w_accept     = req_valid_i & req_ready_o;
    assign w_word_store = req_we_i & (req_size_i == SIZE_W);
    // Read data is valid at the end of the last RD_WAIT cycle.
    assign w_sample     = (state_q == ST_RD_WAIT) && (cnt_q == c_ONE);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_b_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_misaligned) begin
                        state_d = ST_RESP;
                    end else if (w_word_store) begin
                        state_d = ST_WRITE;
                    end else begin
                        // Loads and sub-word stores both need the old word.
                        state_d = ST_RD_WAIT;
                        cnt_d   = c_LAT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == c_ONE) begin
                    state_d = we_q ? ST_WRITE : ST_RESP;
                end else begin
                    cnt_d = cnt_q - c_ONE;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready_o  = (state_q == ST_IDLE) & ~rst_b_i;
        resp_valid_o = (state_q == ST_RESP);
    end

    // ------------------------------------------------------------------
    // Request capture, memory interface and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_b_i) begin
            offset_q          <= '0;
            size_q            <= '0;
            unsigned_q        <= 1'b0;
            we_q              <= 1'b0;
            wdata_q           <= '0;
            mem_addr_q        <= '0;
            mem_data_in_q     <= '0;
            mem_write_en_q    <= 1'b0;
            resp_rdata_q      <= '0;
            resp_misaligned_q <= 1'b0;
        end else begin
            // Registered strobe: high exactly for the cycle spent in WRITE.
            mem_write_en_q <= (state_d == ST_WRITE);

            if (w_accept) begin
                offset_q   <= req_addr_i[1:0];
                size_q     <= req_size_i;
                unsigned_q <= req_unsigned_i;
                we_q       <= req_we_i;
                wdata_q    <= req_wdata_i[15:0];
                if (w_misaligned) begin
                    // Rejected: memory-side outputs keep their last values.
                    resp_rdata_q      <= '0;
                    resp_misaligned_q <= 1'b1;
                end else begin
                    mem_addr_q <= {req_addr_i[31:2], 2'b00};
                    if (w_word_store) begin
                        mem_data_in_q <= req_wdata_i;
                    end
                end
            end

            if (w_sample) begin
                if (we_q) begin
                    mem_data_in_q <= w_merged;
                end else begin
                    resp_rdata_q      <= w_load_data;
                    resp_misaligned_q <= 1'b0;
                end
            end

            if (state_q == ST_WRITE) begin
                resp_rdata_q      <= '0;
                resp_misaligned_q <= 1'b0;
            end
        end
    end

    assign resp_rdata_o      = resp_rdata_q;
    assign resp_misaligned_o = resp_misaligned_q;
    assign mem_addr_o        = mem_addr_q;
    assign mem_data_in_o     = mem_data_in_q;
    assign mem_write_en_o    = mem_write_en_q;

endmodule : riscv_lsu
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_lsu
// Purpose  : Self-checking bench for riscv_lsu with MEM_LATENCY = 2. A
//            behavioural memory returns filler data until the address has
//            been stable long enough, so early sampling shows up as bad data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_lsu;
    import riscv_pkg::*;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_b;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [31:0] mem_addr;
    lane_t       mem_data_in;
    lane_t       mem_data_out;
    logic        mem_write_en;

    riscv_lsu #(.MEM_LATENCY(LAT)) dut (
        .clk_i             (clk),
        .rst_b_i           (rst_b),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_we_i          (req_we),
        .req_size_i        (req_size),
        .req_unsigned_i    (req_unsigned),
        .req_addr_i        (req_addr),
        .req_wdata_i       (req_wdata),
        .resp_valid_o      (resp_valid),
        .resp_rdata_o      (resp_rdata),
        .resp_misaligned_o (resp_misaligned),
        .mem_addr_o        (mem_addr),
        .mem_data_in_o     (mem_data_in),
        .mem_data_out_i    (mem_data_out),
        .mem_write_en_o    (mem_write_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural memory ----------------
    logic [31:0] mem [0:1023];
    logic [31:0] trk_addr;
    int          age;
    int          wr_count;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;
    logic        pre_en;
    logic [9:0]  pre_idx;
    logic [31:0] pre_word;

    initial begin
        trk_addr     = 32'h0;
        age          = 0;
        wr_count     = 0;
        last_wr_addr = 32'h0;
        last_wr_data = 32'h0;
    end

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_addr[11:2]] <= mem_data_in;
            wr_count            <= wr_count + 1;
            last_wr_addr        <= mem_addr;
            last_wr_data        <= mem_data_in;
        end else if (pre_en) begin
            mem[pre_idx] <= pre_word;
        end
        if (mem_addr != trk_addr) begin
            trk_addr <= mem_addr;
            age      <= 1;
        end else if (age < 15) begin
            age <= age + 1;
        end
    end

    always_comb begin
        mem_data_out = 32'hA5A5A5A5;
        if (mem_addr == trk_addr && age >= LAT - 1)
            mem_data_out = mem[mem_addr[11:2]];
    end

    // ---------------- checking ----------------
    int n_checks;
    int n_fail;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic        pre_en;
        logic [31:0] pre_word;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        int          exp_lat;
        int          exp_wr;
        logic [31:0] exp_word;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic pe, input logic [31:0] pw,
                                input logic we, input logic [1:0] sz,
                                input logic un, input logic [31:0] ad,
                                input logic [31:0] wd, input logic [31:0] er,
                                input logic em, input int el, input int ew,
                                input logic [31:0] eword);
        vec_t v;
        v.pre_en = pe;  v.pre_word = pw;  v.we = we;   v.size = sz;
        v.uns = un;     v.addr = ad;      v.wdata = wd;
        v.exp_rdata = er; v.exp_mis = em; v.exp_lat = el; v.exp_wr = ew;
        v.exp_word = eword;
        return v;
    endfunction

    task automatic preload(input logic [31:0] addr, input logic [31:0] word);
        pre_idx  = addr[11:2];
        pre_word = word;
        pre_en   = 1'b1;
        @(posedge clk); #1;
        pre_en   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          cyc;
        int          wr0;
        logic [31:0] addr0;
        logic        busy_ready;
        logic [31:0] aligned;
        aligned = {v.addr[31:2], 2'b00};
        if (v.pre_en) preload(aligned, v.pre_word);
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ready_before_req", idx, {31'b0, req_ready}, 32'h1);
        addr0        = mem_addr;
        wr0          = wr_count;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        cyc        = 1;
        busy_ready = 1'b0;
        while (!resp_valid && cyc < 20) begin
            busy_ready |= req_ready;
            @(posedge clk); #1;
            cyc++;
        end
        busy_ready |= req_ready;
        check("resp_latency", idx, cyc, v.exp_lat);
        check("resp_rdata", idx, resp_rdata, v.exp_rdata);
        check("resp_misaligned", idx, {31'b0, resp_misaligned}, {31'b0, v.exp_mis});
        check("ready_while_busy", idx, {31'b0, busy_ready}, 32'h0);
        check("mem_addr", idx, mem_addr, v.exp_mis ? addr0 : aligned);
        @(posedge clk); #1;
        check("resp_one_cycle", idx, {31'b0, resp_valid}, 32'h0);
        check("ready_after_resp", idx, {31'b0, req_ready}, 32'h1);
        check("write_pulses", idx, wr_count - wr0, v.exp_wr);
        if (v.exp_wr != 0) begin
            check("write_addr", idx, last_wr_addr, aligned);
            check("write_lanes", idx, last_wr_data, v.exp_word);
            check("mem_word", idx, mem[aligned[11:2]], v.exp_word);
        end
    endtask

    initial begin
        int   wr0;
        logic resp_seen;
        n_checks     = 0;
        n_fail       = 0;
        rst_b        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        pre_en       = 1'b0;
        pre_idx      = 10'h0;
        pre_word     = 32'h0;

        //            pre  pre_word      we sz un addr        wdata         rdata         mis lat wr word
        vecs[0]  = mk(1, 32'h12345678, 0, 2, 0, 32'h100, 32'h0,        32'h12345678, 0, 3, 0, 32'h0);
        vecs[1]  = mk(1, 32'h80345678, 0, 0, 0, 32'h103, 32'h0,        32'hFFFFFF80, 0, 3, 0, 32'h0);
        vecs[2]  = mk(0, 32'h0,        0, 0, 1, 32'h103, 32'h0,        32'h00000080, 0, 3, 0, 32'h0);
        vecs[3]  = mk(0, 32'h0,        0, 1, 0, 32'h102, 32'h0,        32'hFFFF8034, 0, 3, 0, 32'h0);
        vecs[4]  = mk(0, 32'h0,        0, 1, 1, 32'h102, 32'h0,        32'h00008034, 0, 3, 0, 32'h0);
        vecs[5]  = mk(0, 32'h0,        0, 0, 0, 32'h100, 32'h0,        32'h00000078, 0, 3, 0, 32'h0);
        vecs[6]  = mk(0, 32'h0,        0, 1, 0, 32'h100, 32'h0,        32'h00005678, 0, 3, 0, 32'h0);
        vecs[7]  = mk(0, 32'h0,        0, 2, 1, 32'h100, 32'h0,        32'h80345678, 0, 3, 0, 32'h0);
        vecs[8]  = mk(0, 32'h0,        0, 2, 0, 32'h101, 32'h0,        32'h0,        1, 1, 0, 32'h0);
        vecs[9]  = mk(0, 32'h0,        1, 1, 0, 32'h203, 32'h1234,     32'h0,        1, 1, 0, 32'h0);
        vecs[10] = mk(0, 32'h0,        0, 3, 0, 32'h100, 32'h0,        32'h0,        1, 1, 0, 32'h0);
        vecs[11] = mk(0, 32'h0,        0, 1, 0, 32'h101, 32'h0,        32'h0,        1, 1, 0, 32'h0);
        vecs[12] = mk(1, 32'h12345678, 1, 1, 0, 32'h102, 32'hAAAABEEF, 32'h0,        0, 4, 1, 32'hBEEF5678);
        vecs[13] = mk(0, 32'h0,        1, 0, 0, 32'h101, 32'h000000CC, 32'h0,        0, 4, 1, 32'hBEEFCC78);
        vecs[14] = mk(0, 32'h0,        1, 2, 0, 32'h200, 32'hDEADBEEF, 32'h0,        0, 2, 1, 32'hDEADBEEF);
        vecs[15] = mk(0, 32'h0,        0, 2, 0, 32'h200, 32'h0,        32'hDEADBEEF, 0, 3, 0, 32'h0);
        vecs[16] = mk(0, 32'h0,        0, 0, 0, 32'h202, 32'h0,        32'hFFFFFFAD, 0, 3, 0, 32'h0);
        vecs[17] = mk(0, 32'h0,        0, 1, 1, 32'h202, 32'h0,        32'h0000DEAD, 0, 3, 0, 32'h0);

        // Reset state, sampled while reset is still asserted.
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", -1, {31'b0, req_ready}, 32'h0);
        check("rst_resp_valid", -1, {31'b0, resp_valid}, 32'h0);
        check("rst_resp_mis", -1, {31'b0, resp_misaligned}, 32'h0);
        check("rst_resp_rdata", -1, resp_rdata, 32'h0);
        check("rst_mem_we", -1, {31'b0, mem_write_en}, 32'h0);
        check("rst_mem_addr", -1, mem_addr, 32'h0);
        check("rst_mem_data_in", -1, mem_data_in, 32'h0);
        rst_b = 1'b0;
        #1;
        check("ready_after_rst", -1, {31'b0, req_ready}, 32'h1);
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Reset during the read phase of a sub-word store.
        preload(32'h104, 32'h11223344);
        wr0          = wr_count;
        req_we       = 1'b1;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h104;
        req_wdata    = 32'h00000055;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_busy_ready", 100, {31'b0, req_ready}, 32'h0);
        rst_b = 1'b1;
        @(posedge clk); #1;
        check("abort_ready_in_rst", 100, {31'b0, req_ready}, 32'h0);
        rst_b = 1'b0;
        #1;
        check("abort_ready_after", 100, {31'b0, req_ready}, 32'h1);
        check("abort_mem_addr", 100, mem_addr, 32'h0);
        resp_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            resp_seen |= resp_valid;
            @(posedge clk); #1;
        end
        check("abort_no_resp", 100, {31'b0, resp_seen}, 32'h0);
        check("abort_no_write", 100, wr_count - wr0, 0);
        check("abort_mem_kept", 100, mem[10'h41], 32'h11223344);

        // Unit resumes normal operation after the abort.
        run_vec(mk(0, 32'h0, 0, 2, 0, 32'h104, 32'h0, 32'h11223344, 0, 3, 0, 32'h0), 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_riscv_lsu
`default_nettype wire

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit directly downstream of the core's memory request path; sits between the core and the byte-lane data memory.
- Accepts one request at a time: LB/LH/LW/LBU/LHU/SB/SH/SW.
- Aligns and sign/zero-extends load data.
- Performs read-modify-write for sub-word stores, since memory has only a whole-word write enable.

Parameters:
- MEM_LATENCY, 1, cycles between a stable mem_addr and valid mem_data_out (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  reset: synchronous, active-high (despite the name).
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  zero-extend loads (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low bytes used for sub-word stores.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_misaligned  out  1  request rejected: misaligned or illegal size.
- mem_addr  out  32  word-aligned address, bits [1:0] = 0.
- mem_data_in  out  4x8  write lanes; lane k = byte at address +k (little-endian).
- mem_data_out  in  4x8  read lanes, same lane mapping.
- mem_write_en  out  1  whole-word write strobe.

Behaviour:
- Reset (rst_b = 1 at an edge):
  - State → IDLE; counter cleared; request and merge registers cleared.
  - resp_valid, resp_misaligned, mem_write_en, mem_addr, mem_data_in, resp_rdata all 0.
  - req_ready forced 0 while rst_b = 1.
  - Reset mid-operation abandons the transaction: no write is issued afterwards and no response is given.
- Handshake:
  - req_ready = 1 only in IDLE.
  - A request is accepted at an edge where req_valid & req_ready; all req_* fields are registered then.
  - No response backpressure.
- States: IDLE, RD_WAIT, WRITE, RESP.
- Misaligned / illegal request: size 3; half with addr[0] = 1; word with addr[1:0] ≠ 0.
  - IDLE → RESP. No memory access.
  - resp_misaligned = 1, resp_rdata = 0.
- Load: IDLE → RD_WAIT.
  - mem_addr = {addr[31:2], 2'b00} is held; counter loads MEM_LATENCY.
  - mem_data_out is sampled at the end of the MEM_LATENCY-th RD_WAIT cycle, then → RESP.
  - resp_valid is high in cycle MEM_LATENCY+1 after the accept edge.
- Load extraction:
  - Byte = lane addr[1:0].
  - Half = lanes {addr[1]*2+1, addr[1]*2}.
  - Sign-extend unless req_unsigned; req_unsigned is ignored for words.
- Word store: IDLE → WRITE.
  - mem_write_en = 1 for exactly one cycle; mem_addr aligned; mem_data_in = wdata lanes.
  - Then → RESP; resp_valid in cycle 2.
- Sub-word store: IDLE → RD_WAIT (same read timing as a load).
  - Merge new byte(s) into the sampled word; other lanes unchanged.
  - → WRITE (single write) → RESP; resp_valid in cycle MEM_LATENCY+2.
- RESP:
  - resp_valid = 1 for one cycle, then → IDLE.
  - The next request can be accepted the cycle after RESP.
- Output rules:
  - mem_write_en is driven from a register and is 1 only in WRITE.
  - mem_addr and mem_data_in hold their last values otherwise.
  - resp_rdata and resp_misaligned hold until the next response; they are only meaningful with resp_valid.
- Address arithmetic: no wrap handling needed; accesses never cross a word, because misaligned requests are rejected.

Decomposition:
- Shared package riscv_pkg holds:
  - mem_size_t enum (SIZE_B, SIZE_H, SIZE_W).
  - lsu_state_t enum.
  - lane type (4x8 array).
  - LSU_SIZE_ILLEGAL constant.
- One combinational sub-module, riscv_lsu_lane_align:
  - load extract/extend.
  - store merge.
  - misalignment check.
- The FSM and counter stay in riscv_lsu.

Test Plan:
1. MEM_LATENCY = 2, memory word at 0x100 = lanes {78,56,34,12}; LW 0x100 → resp_valid in cycle 3 after accept, rdata 0x12345678, mem_write_en never 1.
2. Lane 3 of 0x100 = 0x80; LB 0x103 → rdata 0xFFFFFF80; LBU 0x103 → 0x00000080; LH 0x102 with lanes 2/3 = {34,80} → 0xFFFF8034.
3. Memory 0x12345678 at 0x100; SH 0x102, wdata 0xAAAABEEF → exactly one mem_write_en pulse, mem_addr 0x100, lanes {78,56,EF,BE}; resp_valid in cycle MEM_LATENCY+2.
4. LW 0x101, then SH 0x203, then req_size 3 → each: resp_misaligned = 1, rdata 0, resp_valid in cycle 1, no mem_write_en, mem_addr unchanged.
5. SB 0x104 accepted; rst_b = 1 during RD_WAIT → mem_write_en never rises, resp_valid never rises, req_ready = 1 the cycle after rst_b drops.
6. SW 0x200 = 0xDEADBEEF, then LW 0x200 issued as soon as req_ready → SW response in cycle 2; LW returns 0xDEADBEEF; req_ready low throughout both transactions except IDLE.
